component_table_reader: RTL
===========================

// Module: component_table_reader
// PURPOSE
//   Frame-end readout engine for the labeling stage. After a frame it walks
//   labels 1..num_labels-1 and follows each label's merge-table links to its
//   root (smallest equivalent label). It reads the label's data-table
//   accumulation and streams {label, root, data} to a valid/ready consumer.
//   It is the reader of the merge and data tables the labeler writes; it
//   drives their read ports while the labeler is idle between frames.
// PARAMETERS
//   WORD_SIZE   `WORD_SIZE  label width; merge-table address and data width
//   DATA_WIDTH  24          data-table entry width
// PORTS
//   clk           in   1           single clock, all logic on posedge
//   reset         in   1           synchronous, active-high
//   start         in   1           begin readout; sampled only in IDLE
//   num_labels    in   WORD_SIZE   labeler count (next free label); 0 reserved
//   merge_r_addr  out  WORD_SIZE   merge-table read address
//   merge_data    in   WORD_SIZE   merge-table read data, 1 cycle after address
//   data_r_addr   out  WORD_SIZE   data-table read address
//   data_data     in   DATA_WIDTH  data-table read data, 1 cycle after address
//   out_valid     out  1           output record valid
//   out_ready     in   1           consumer accepts record
//   out_label     out  WORD_SIZE   label being reported
//   out_root      out  WORD_SIZE   resolved root of out_label
//   out_data      out  DATA_WIDTH  data-table value of out_label
//   busy          out  1           high whenever state != IDLE
//   done          out  1           one-cycle pulse at end of readout
//   error         out  1           sticky: corrupt merge link seen
// BEHAVIOUR
//   - Reset: state IDLE. out_valid=0, done=0, busy=0, error=0.
//     out_label/out_root/out_data=0. Both read addresses=0.
//   - Reset mid-operation aborts immediately. No further records are emitted.
//   - Each read address is driven from an internal register. RAM data is
//     sampled in the cycle after the address is presented.
//   - IDLE, start=1: latch N=num_labels and clear error.
//     If N<=1, go to DONE; otherwise set i=1, cur=1 and go to M_READ.
//   - start while busy is ignored.
//   - M_READ: merge_r_addr=cur; go to M_CHK.
//   - M_CHK: compare p=merge_data.
//     * p==cur or p==0: root=cur; go to D_READ.
//     * 0<p<cur: cur=p; go to M_READ. One hop costs 2 cycles.
//     * p>cur or p>=N: error=1, root=cur; go to D_READ. Never loops.
//   - D_READ: data_r_addr=i; go to D_CAP.
//   - D_CAP: capture out_data=data_data, out_label=i, out_root=root; go to EMIT.
//   - EMIT: out_valid=1 with all fields held stable until out_ready=1.
//     On handshake:
//     * if i==N-1, go to DONE;
//     * else set i=i+1, cur=i+1 and go to M_READ.
//     out_valid drops the cycle after the handshake.
//   - DONE: done=1 for exactly one cycle; next state IDLE.
//   - Latency: start accepted at cycle 0. The label needing h hops has
//     out_valid at cycle 2h+5 when out_ready is held high.
//     Each label takes 2h+5 cycles per record.
//   - Counters are WORD_SIZE wide. N=2^WORD_SIZE-1 is legal; i never wraps
//     because termination is on i==N-1.
//   - The merge table is never written by this block; all root resolution
//     is held locally.
// TESTING
//   1. N=1, start -> no out_valid; busy=1 and done=1 in cycle 1; IDLE cycle 2.
//   2. N=4, merge m[i]=i, data {10,20,30}, ready=1 -> records (1,1,10),
//      (2,2,20), (3,3,30); out_valid at cycles 5, 10, 15; done at 16.
//   3. N=4, m={1:1,2:1,3:2}, data[3]=7 -> label 3 record (3,1,7);
//      first valid 2 hops later than the identity case; error=0.
//   4. Case 2 with out_ready=0 for 10 cycles at the first record ->
//      (1,1,10) held stable; exactly one transfer; total order unchanged.
//   5. N=4, m[2]=5 -> error=1, record (2,2,data[2]); readout completes
//      with done; error clears on next start.
//   6. Reset asserted during M_CHK of label 2 -> next cycle busy=0,
//      out_valid=0; a later start reruns from label 1 correctly.

Source files
------------

// File: rtl/component_table_reader.sv
// Frame-end readout: walks labels 1..N-1, resolves each root through the merge table,
// fetches the label's data-table entry and streams {label, root, data} over valid/ready.
module component_table_reader #(
    parameter int unsigned WORD_SIZE  = 8,
    parameter int unsigned DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_SIZE-1:0]  num_labels,
    output logic [WORD_SIZE-1:0]  merge_r_addr,
    input  logic [WORD_SIZE-1:0]  merge_data,
    output logic [WORD_SIZE-1:0]  data_r_addr,
    input  logic [DATA_WIDTH-1:0] data_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_SIZE-1:0]  out_label,
    output logic [WORD_SIZE-1:0]  out_root,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic [2:0] {
        StIdle, StMRead, StMChk, StDRead, StDCap, StEmit, StDone
    } state_e;

    localparam logic [WORD_SIZE-1:0] One = WORD_SIZE'(1);

    state_e                  state_q, state_d;
    logic [WORD_SIZE-1:0]    n_q, n_d;
    logic [WORD_SIZE-1:0]    i_q, i_d;
    logic [WORD_SIZE-1:0]    cur_q, cur_d;
    logic [WORD_SIZE-1:0]    root_q, root_d;
    logic [WORD_SIZE-1:0]    maddr_q, maddr_d;
    logic [WORD_SIZE-1:0]    daddr_q, daddr_d;
    logic [WORD_SIZE-1:0]    label_q, label_d;
    logic [WORD_SIZE-1:0]    oroot_q, oroot_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    error_q, error_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            n_q     <= '0;
            i_q     <= '0;
            cur_q   <= '0;
            root_q  <= '0;
            maddr_q <= '0;
            daddr_q <= '0;
            label_q <= '0;
            oroot_q <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            i_q     <= i_d;
            cur_q   <= cur_d;
            root_q  <= root_d;
            maddr_q <= maddr_d;
            daddr_q <= daddr_d;
            label_q <= label_d;
            oroot_q <= oroot_d;
            data_q  <= data_d;
            error_q <= error_d;
        end
    end

    // Read addresses are loaded on entry to M_READ / D_READ so the RAM sees them
    // during that state and returns data in the following (check/capture) state.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        i_d     = i_q;
        cur_d   = cur_q;
        root_d  = root_q;
        maddr_d = maddr_q;
        daddr_d = daddr_q;
        label_d = label_q;
        oroot_d = oroot_q;
        data_d  = data_q;
        error_d = error_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    n_d     = num_labels;
                    error_d = 1'b0;
                    if (num_labels <= One) begin
                        state_d = StDone;
                    end else begin
                        i_d     = One;
                        cur_d   = One;
                        maddr_d = One;
                        state_d = StMRead;
                    end
                end
            end
            StMRead: state_d = StMChk;
            StMChk: begin
                if (merge_data == cur_q || merge_data == '0) begin
                    root_d  = cur_q;
                    daddr_d = i_q;
                    state_d = StDRead;
                end else if (merge_data < cur_q) begin
                    cur_d   = merge_data;
                    maddr_d = merge_data;
                    state_d = StMRead;
                end else begin
                    // Forward link is corrupt; stop walking so a bad table cannot loop.
                    error_d = 1'b1;
                    root_d  = cur_q;
                    daddr_d = i_q;
                    state_d = StDRead;
                end
            end
            StDRead: state_d = StDCap;
            StDCap: begin
                label_d = i_q;
                oroot_d = root_q;
                data_d  = data_data;
                state_d = StEmit;
            end
            StEmit: begin
                if (out_ready) begin
                    if (i_q == n_q - One) begin
                        state_d = StDone;
                    end else begin
                        i_d     = i_q + One;
                        cur_d   = i_q + One;
                        maddr_d = i_q + One;
                        state_d = StMRead;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign merge_r_addr = maddr_q;
    assign data_r_addr  = daddr_q;
    assign out_valid    = (state_q == StEmit);
    assign out_label    = label_q;
    assign out_root     = oroot_q;
    assign out_data     = data_q;
    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign error        = error_q;

endmodule
